// File: rtl/ppu_text.sv
// ppu_text: attribute text-mode renderer.
// Fetches one text row (character + attribute bytes) from video RAM into a
// line buffer during horizontal blanking. It then renders each pixel from a
// registered font ROM lookup, using per-cell foreground/background colours and
// a blinking cursor.
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   sx, sy, line, frame, de  display timing inputs (coordinates are signed)
//   vid_rd, vid_address, vid_data  video RAM read port (data one cycle after strobe)
//   font_addr, font_data   font ROM port (data one cycle after address)
//   cursor_en/col/row      cursor control
//   paint_r/g/b, de_out    pixel colour and aligned display enable (latency 2)
//   busy, underrun         row fetch in progress, sticky late-fetch flag
module ppu_text #(
  parameter int CORDW        = 12,
  parameter int H_RES        = 1024,
  parameter int V_RES        = 600,
  parameter int CHANW        = 4,
  parameter int SCALE        = 2,
  parameter int ADDRW        = 15,
  parameter int CHAR_BASE    = 'h1000,
  parameter int ATTR_BASE    = 'h1800,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             line,
  input  logic             frame,
  input  logic             de,
  output logic             vid_rd,
  output logic [ADDRW-1:0] vid_address,
  input  logic [7:0]       vid_data,
  output logic [10:0]      font_addr,
  input  logic [7:0]       font_data,
  input  logic             cursor_en,
  input  logic [6:0]       cursor_col,
  input  logic [5:0]       cursor_row,
  output logic [CHANW-1:0] paint_r,
  output logic [CHANW-1:0] paint_g,
  output logic [CHANW-1:0] paint_b,
  output logic             de_out,
  output logic             busy,
  output logic             underrun
);
  localparam int COLS  = H_RES / (8 * SCALE);
  localparam int ROWS  = V_RES / (8 * SCALE);
  localparam int SHIFT = $clog2(SCALE);
  localparam int CIW   = $clog2(COLS);
  localparam int FIW   = CIW + 1;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [CORDW-1:0] COLS_C = CORDW'(COLS);
  localparam logic [CORDW-1:0] ROWS_C = CORDW'(ROWS);
  localparam logic [FIW-1:0]   COLS_F = FIW'(COLS);
  localparam logic [FIW-1:0]   LAST_F = FIW'(2 * COLS - 1);
  localparam logic [ADDRW-1:0] COLS_A = ADDRW'(COLS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t           r_state;
  logic             r_busy, r_valid, r_vid_rd;
  logic [ADDRW-1:0] r_vid_addr, r_base;
  logic [FIW-1:0]   r_fidx, r_wr_idx;
  logic             r_wr_en;
  logic [7:0]       r_char_buf [COLS];
  logic [7:0]       r_attr_buf [COLS];
  logic [BW-1:0]    r_blink_cnt;
  logic             r_phase, r_de_d, r_underrun;
  logic             r1_de, r1_vis, r1_cur;
  logic [2:0]       r1_xoff;
  logic [7:0]       r1_attr;
  logic [CHANW-1:0] r_paint_r, r_paint_g, r_paint_b;
  logic             r_de_out;

  // Coordinates are treated as unsigned bit patterns. A negative value then
  // maps to a huge row/column, so it falls outside the text area without any
  // extra sign checks.
  logic [CORDW-1:0] w_sx_s, w_sy_s, w_col, w_tr;
  logic [2:0]       w_xoff, w_yoff;
  logic [CIW-1:0]   w_cidx;
  logic [ADDRW-1:0] w_row_base;
  logic             w_vis, w_cur;
  logic [3:0]       w_fg, w_bg, w_ci;
  logic             w_pix;

  assign w_sx_s     = sx >> SHIFT;
  assign w_sy_s     = sy >> SHIFT;
  assign w_col      = w_sx_s >> 3;
  assign w_tr       = w_sy_s >> 3;
  assign w_xoff     = w_sx_s[2:0];
  assign w_yoff     = w_sy_s[2:0];
  assign w_cidx     = w_col[CIW-1:0];
  assign w_row_base = ADDRW'(w_tr) * COLS_A;

  function automatic logic [ADDRW-1:0] f_addr(input logic [ADDRW-1:0] base,
                                              input logic [FIW-1:0]   k);
    if (k < COLS_F) f_addr = ADDRW'(CHAR_BASE) + base + ADDRW'(k);
    else            f_addr = ADDRW'(ATTR_BASE) + base + ADDRW'(k - COLS_F);
  endfunction

  function automatic logic [CHANW-1:0] f_chan(input logic en, input logic inten);
    if (!en)       f_chan = '0;
    else if (inten) f_chan = '1;
    else           f_chan = {1'b0, {(CHANW-1){1'b1}}};
  endfunction

  // Row fetch FSM. The test tr < ROWS also implies 0 <= sy < V_RES.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_vid_rd   <= 1'b0;
      r_vid_addr <= '0;
      r_base     <= '0;
      r_fidx     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_wr_en  <= r_vid_rd;
      r_wr_idx <= r_fidx;
      case (r_state)
        S_IDLE: begin
          if (line) begin
            if (w_yoff == 3'd0 && w_tr < ROWS_C) begin
              r_state    <= S_FETCH;
              r_busy     <= 1'b1;
              r_valid    <= 1'b0;
              r_vid_rd   <= 1'b1;
              r_fidx     <= '0;
              r_base     <= w_row_base;
              r_vid_addr <= f_addr(w_row_base, FIW'(0));
            end else if (w_tr >= ROWS_C) begin
              r_valid <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (r_fidx == LAST_F) begin
            r_vid_rd <= 1'b0;
            r_state  <= S_DRAIN;
          end else begin
            r_fidx     <= r_fidx + 1'b1;
            r_vid_addr <= f_addr(r_base, r_fidx + 1'b1);
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line buffer: each returned byte lands in its slot one cycle after its strobe.
  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      if (r_wr_idx < COLS_F) r_char_buf[r_wr_idx[CIW-1:0]]      <= vid_data;
      else                   r_attr_buf[CIW'(r_wr_idx - COLS_F)] <= vid_data;
    end
  end

  // Cursor blink phase and underrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_de_d      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_de_d <= de;
      if (frame) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      if (frame)                      r_underrun <= 1'b0;
      else if (de && !r_de_d && r_busy) r_underrun <= 1'b1;
    end
  end

  // Stage 1: the font address comes straight from the buffer, so the font
  // ROM's registered output lines up with stage 2.
  assign font_addr = {r_char_buf[w_cidx], w_yoff};
  assign w_vis     = r_valid && (w_tr < ROWS_C) && (w_col < COLS_C);
  assign w_cur     = cursor_en && r_phase && (w_col == CORDW'(cursor_col)) &&
                     (w_tr == CORDW'(cursor_row));

  // Stage 2: glyph bit select and colour expansion.
  assign w_fg  = r1_cur ? r1_attr[3:0] : r1_attr[7:4];
  assign w_bg  = r1_cur ? r1_attr[7:4] : r1_attr[3:0];
  assign w_pix = font_data[3'd7 - r1_xoff];
  assign w_ci  = w_pix ? w_fg : w_bg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_de     <= 1'b0;
      r1_vis    <= 1'b0;
      r1_cur    <= 1'b0;
      r1_xoff   <= '0;
      r1_attr   <= '0;
      r_de_out  <= 1'b0;
      r_paint_r <= '0;
      r_paint_g <= '0;
      r_paint_b <= '0;
    end else begin
      r1_de    <= de;
      r1_vis   <= w_vis;
      r1_cur   <= w_cur;
      r1_xoff  <= w_xoff;
      r1_attr  <= r_attr_buf[w_cidx];
      r_de_out <= r1_de;
      if (r1_de && r1_vis) begin
        r_paint_r <= f_chan(w_ci[2], w_ci[3]);
        r_paint_g <= f_chan(w_ci[1], w_ci[3]);
        r_paint_b <= f_chan(w_ci[0], w_ci[3]);
      end else begin
        r_paint_r <= '0;
        r_paint_g <= '0;
        r_paint_b <= '0;
      end
    end
  end

  assign vid_rd      = r_vid_rd;
  assign vid_address = r_vid_addr;
  assign busy        = r_busy;
  assign underrun    = r_underrun;
  assign de_out      = r_de_out;
  assign paint_r     = r_paint_r;
  assign paint_g     = r_paint_g;
  assign paint_b     = r_paint_b;
endmodule

// File: tb/tb_ppu_text.sv
// tb_ppu_text: self-checking bench for ppu_text (default geometry, BLINK_FRAMES=2).
// The bench provides behavioural video RAM and font ROM models. Expected pixels
// come from a reference model that applies the text-mode rules directly to the
// RAM/ROM contents.
module tb_ppu_text;
  localparam int CB = 'h1000;
  localparam int AB = 'h1800;

  logic        clk = 1'b0;
  logic        rst, line, frame, de, cursor_en;
  logic [11:0] sx, sy;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        vid_rd, de_out, busy, underrun;
  logic [14:0] vid_address;
  logic [7:0]  vid_data = 8'h00;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [3:0]  paint_r, paint_g, paint_b;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] vram [0:32767];
  logic [7:0] font [0:2047];

  bit m_valid = 1'b0;
  int m_row   = 0;
  int m_frames = 0;

  always #5 clk = ~clk;

  ppu_text #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .sx(sx), .sy(sy), .line(line), .frame(frame), .de(de),
    .vid_rd(vid_rd), .vid_address(vid_address), .vid_data(vid_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .paint_r(paint_r), .paint_g(paint_g), .paint_b(paint_b),
    .de_out(de_out), .busy(busy), .underrun(underrun)
  );

  always @(posedge clk) begin
    if (vid_rd) vid_data <= vram[vid_address];
    font_data <= font[font_addr];
  end

  function automatic logic [3:0] chan(input int ci, input int b);
    if (((ci >> b) & 1) == 0) return 4'h0;
    return (ci >= 8) ? 4'hF : 4'h7;
  endfunction

  // Reference pixel: {de_out, r, g, b}. The line buffer holds row m_row when m_valid.
  function automatic logic [12:0] model(input int x, input int y, input bit d);
    int tr, yo, col, xo, ch, at, fg, bg, ci, t;
    bit pix;
    if (!d) return 13'h0;
    tr = (y / 2) / 8; yo = (y / 2) % 8;
    col = (x / 2) / 8; xo = (x / 2) % 8;
    if (!m_valid || tr >= 37 || col >= 64) return 13'h1000;
    ch  = vram[CB + m_row * 64 + col];
    at  = vram[AB + m_row * 64 + col];
    pix = font[ch * 8 + yo][7 - xo];
    fg  = at / 16;
    bg  = at % 16;
    if (cursor_en && ((m_frames / 2) % 2) == 1 && col == cursor_col && tr == cursor_row) begin
      t = fg; fg = bg; bg = t;
    end
    ci = pix ? fg : bg;
    return {1'b1, chan(ci, 2), chan(ci, 1), chan(ci, 0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line_pulse(input int y);
    sy = 12'(y); line = 1'b1;
    tick();
    line = 1'b0;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    m_frames++;
  endtask

  task automatic fetch_row(input int y);
    int strobes;
    strobes = 0;
    line_pulse(y);
    m_valid = 1'b0;
    for (int t = 0; t < 400 && busy; t++) begin
      if (vid_rd) strobes++;
      tick();
    end
    chk("fetch_done", 32'(busy), 32'd0);
    chk("fetch_strobes", strobes, 128);
    m_valid = 1'b1;
    m_row = (y / 2) / 8;
  endtask

  task automatic render_span(input int y, input int x0, input int n, input bit rand_de);
    logic [12:0] exq[$];
    sy = 12'(y);
    for (int k = 0; k < n + 2; k++) begin
      bit d;
      d  = (k < n) && (!rand_de || ($urandom % 8) != 0);
      sx = 12'(x0 + k);
      de = d;
      exq.push_back(model(x0 + k, y, d));
      tick();
      if (k >= 1) chk("pixel", {19'd0, de_out, paint_r, paint_g, paint_b}, 32'(exq[k-1]));
    end
    de = 1'b0;
  endtask

  task automatic show(input int x, input int y, input string name, input logic [12:0] exp);
    sx = 12'(x); sy = 12'(y); de = 1'b1;
    tick(); tick();
    chk(name, {19'd0, de_out, paint_r, paint_g, paint_b}, 32'(exp));
  endtask

  typedef struct {
    int          x;
    bit          d;
    logic [12:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int nstrobe, nbusy, cnt, r, nf;
    logic [31:0] exp_a;

    // Cell 0 of row 0: char 'h41, attr 'h1E, glyph row 0 = 'h81.
    // fg=1 -> (0,0,7); bg=E -> (F,F,0).
    vecs[0] = '{0,    1'b1, 13'h1007};
    vecs[1] = '{1,    1'b1, 13'h1007};
    vecs[2] = '{2,    1'b1, 13'h1FF0};
    vecs[3] = '{7,    1'b1, 13'h1FF0};
    vecs[4] = '{13,   1'b1, 13'h1FF0};
    vecs[5] = '{14,   1'b1, 13'h1007};
    vecs[6] = '{15,   1'b1, 13'h1007};
    vecs[7] = '{1024, 1'b1, 13'h1000};
    vecs[8] = '{1100, 1'b1, 13'h1000};
    vecs[9] = '{0,    1'b0, 13'h0000};

    for (int i = 0; i < 32768; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++)  font[i] = 8'($urandom);
    vram[CB] = 8'h41;              vram[AB] = 8'h1E;
    vram[CB + 2*64 + 3] = 8'h41;   vram[AB + 2*64 + 3] = 8'h1E;
    font[8'h41 * 8] = 8'h81;

    rst = 1'b1; line = 1'b0; frame = 1'b0; de = 1'b1; sx = '0; sy = '0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    repeat (3) tick();
    chk("rst_paint", {paint_r, paint_g, paint_b}, 0);
    chk("rst_de_out", 32'(de_out), 0);
    chk("rst_vid_rd", 32'(vid_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst = 1'b0; de = 1'b0;
    tick();

    // Row 2 fetch: address sequence and busy length.
    line_pulse(32);
    m_valid = 1'b0;
    nstrobe = 0; nbusy = 0;
    for (int t = 0; t < 300; t++) begin
      if (busy) nbusy++;
      if (vid_rd) begin
        exp_a = (nstrobe < 64) ? 32'(CB + 2*64 + nstrobe) : 32'(AB + 2*64 + nstrobe - 64);
        chk("fetch_addr", 32'(vid_address), exp_a);
        nstrobe++;
      end
      tick();
    end
    chk("fetch_count", nstrobe, 128);
    chk("busy_cycles", nbusy, 129);
    m_valid = 1'b1; m_row = 2;

    // Cursor at (3,2) with a two-frame blink half-period.
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2;
    show(48, 32, "cursor_off_fg", 13'h1007);
    show(56, 32, "cursor_off_bg", 13'h1FF0);
    render_span(32, 40, 32, 1'b0);
    frame_pulse();
    show(48, 32, "cursor_one_frame", 13'h1007);
    frame_pulse();
    show(48, 32, "cursor_on_fg", 13'h1FF0);
    show(56, 32, "cursor_on_bg", 13'h1007);
    render_span(32, 40, 32, 1'b0);
    frame_pulse();
    frame_pulse();
    show(48, 32, "cursor_restored", 13'h1007);
    de = 1'b0;
    cursor_en = 1'b0;

    // Vector table on row 0.
    fetch_row(0);
    sy = 12'd0;
    for (int i = 0; i < 10; i++) begin
      sx = 12'(vecs[i].x); de = vecs[i].d;
      tick(); tick();
      chk("vector", {19'd0, de_out, paint_r, paint_g, paint_b}, 32'(vecs[i].exp));
    end
    de = 1'b0;
    render_span(0, 0, 40, 1'b0);

    // Underrun: de rises 20 cycles into a row fetch.
    line_pulse(48);
    m_valid = 1'b0;
    repeat (19) tick();
    chk("busy_at_de", 32'(busy), 1);
    chk("underrun_pre", 32'(underrun), 0);
    sx = '0; de = 1'b1;
    tick();
    chk("underrun_set", 32'(underrun), 1);
    de = 1'b0;
    for (int t = 0; t < 300 && busy; t++) tick();
    chk("underrun_fetch_done", 32'(busy), 0);
    tick();
    chk("underrun_hold", 32'(underrun), 1);
    frame_pulse();
    chk("underrun_clear", 32'(underrun), 0);
    m_valid = 1'b1; m_row = 3;
    render_span(50, 100, 24, 1'b0);

    // Line beyond the last text row.
    line_pulse(592);
    m_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 200; t++) begin
      if (vid_rd || busy) cnt++;
      tick();
    end
    chk("oob_strobes", cnt, 0);
    show(100, 592, "oob_blank", 13'h1000);
    de = 1'b0;
    render_span(592, 0, 40, 1'b0);
    render_span(592, 1000, 30, 1'b0);

    // Reset after ten strobes of a fetch.
    line_pulse(16);
    cnt = 0;
    for (int t = 0; t < 50; t++) begin
      if (vid_rd) cnt++;
      if (cnt == 10) break;
      tick();
    end
    chk("rst_mid_strobes", cnt, 10);
    rst = 1'b1;
    tick();
    chk("rst_mid_vid_rd", 32'(vid_rd), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0;
    m_valid = 1'b0; m_frames = 0;
    cnt = 0;
    for (int t = 0; t < 150; t++) begin
      if (vid_rd) cnt++;
      tick();
    end
    chk("rst_mid_no_strobes", cnt, 0);
    show(0, 16, "rst_mid_blank", 13'h1000);
    de = 1'b0;
    render_span(16, 0, 32, 1'b0);

    // Randomized rows, cursor positions, blink phases and spans.
    for (int it = 0; it < 6; it++) begin
      r = $urandom_range(0, 36);
      fetch_row(r * 16);
      cursor_en  = 1'($urandom_range(0, 1));
      cursor_col = 7'($urandom_range(0, 63));
      cursor_row = 6'(r);
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) frame_pulse();
      render_span(r * 16 + $urandom_range(0, 15), $urandom_range(0, 1000), 48, 1'b1);
      render_span(r * 16 + $urandom_range(0, 15), int'(cursor_col) * 16, 32, 1'b1);
      render_span($urandom_range(0, 599), 1000, 40, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
